// File: rtl/sram_arbiter_if.sv
// Requester-side bundle for sram_arbiter: display reader, store writer and HDR read/write port.
// Requesters use the master modport, and the arbiter uses the slave modport. Each requester holds its request until it sees gnt.
interface sram_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic [DATA_W-1:0] disp_rdata;
  logic              disp_rvalid;

  logic              st_req;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_wdata;
  logic              st_gnt;

  logic              hdr_req;
  logic              hdr_we;
  logic [ADDR_W-1:0] hdr_addr;
  logic [DATA_W-1:0] hdr_wdata;
  logic              hdr_gnt;
  logic [DATA_W-1:0] hdr_rdata;
  logic              hdr_rvalid;

  modport master (
    output disp_req, disp_addr,
    input  disp_gnt, disp_rdata, disp_rvalid,
    output st_req, st_addr, st_wdata,
    input  st_gnt,
    output hdr_req, hdr_we, hdr_addr, hdr_wdata,
    input  hdr_gnt, hdr_rdata, hdr_rvalid
  );

  modport slave (
    input  disp_req, disp_addr,
    output disp_gnt, disp_rdata, disp_rvalid,
    input  st_req, st_addr, st_wdata,
    output st_gnt,
    input  hdr_req, hdr_we, hdr_addr, hdr_wdata,
    output hdr_gnt, hdr_rdata, hdr_rvalid
  );
endinterface

// File: rtl/sram_arbiter.sv
// Three-way arbiter/sequencer for one async 16-bit SRAM; read data returns 2 cycles after gnt, one access per cycle.
// Losers see gnt=0 and keep requesting; display always wins. SRAM_TURNAROUND_EN inserts an idle bus cycle for read-after-write.
module sram_arbiter #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) (
  input  logic              avm_clk,
  input  logic              avm_rst,
  sram_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  inout  wire  [DATA_W-1:0] io_SRAM_DQ,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N
);

  typedef enum logic {
    RR_ST  = 1'b0,
    RR_HDR = 1'b1
  } rr_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_HDR  = 2'd2
  } tag_t;

  rr_t               rr_last;
  tag_t              tag_q;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_n_q;
  logic              oe_n_q;
  logic              ce_n_q;
  logic              dq_oe_q;

  logic [DATA_W-1:0] disp_rdata_q;
  logic [DATA_W-1:0] hdr_rdata_q;
  logic              disp_rvalid_q;
  logic              hdr_rvalid_q;

  logic              disp_gnt_c;
  logic              st_gnt_c;
  logic              hdr_gnt_c;
  logic              st_wins;
  logic              any_gnt;
  logic              gnt_write;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_wdata;
  logic              rd_block;

`ifdef SRAM_TURNAROUND_EN
  // A read may not follow a write on the bus; it only looks at the previous cycle's grant.
  logic last_wr_q;

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      last_wr_q <= 1'b0;
    end else begin
      last_wr_q <= gnt_write;
    end
  end

  assign rd_block = last_wr_q;
`else
  assign rd_block = 1'b0;
`endif

  always_comb begin
    disp_gnt_c = 1'b0;
    st_gnt_c   = 1'b0;
    hdr_gnt_c  = 1'b0;
    if (bus.st_req && bus.hdr_req) begin
      st_wins = (rr_last == RR_HDR);
    end else begin
      st_wins = bus.st_req;
    end
    // A blocked read winner leaves every grant low; it does not fall through to a lower-priority writer.
    if (!avm_rst) begin
      if (bus.disp_req) begin
        disp_gnt_c = !rd_block;
      end else if (st_wins) begin
        st_gnt_c = 1'b1;
      end else if (bus.hdr_req) begin
        hdr_gnt_c = bus.hdr_we || !rd_block;
      end
    end
  end

  assign any_gnt   = disp_gnt_c || st_gnt_c || hdr_gnt_c;
  assign gnt_write = st_gnt_c || (hdr_gnt_c && bus.hdr_we);
  assign gnt_addr  = disp_gnt_c ? bus.disp_addr :
                     st_gnt_c   ? bus.st_addr   : bus.hdr_addr;
  assign gnt_wdata = st_gnt_c ? bus.st_wdata : bus.hdr_wdata;

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      ce_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
      rr_last <= RR_HDR;
    end else begin
      if (any_gnt) begin
        addr_q  <= gnt_addr;
        we_n_q  <= !gnt_write;
        oe_n_q  <= gnt_write;
        ce_n_q  <= 1'b0;
        dq_oe_q <= gnt_write;
        if (gnt_write) begin
          wdata_q <= gnt_wdata;
        end
      end else begin
        // The address is left unchanged while the bus is idle.
        we_n_q  <= 1'b1;
        oe_n_q  <= 1'b1;
        ce_n_q  <= 1'b1;
        dq_oe_q <= 1'b0;
      end
      if (st_gnt_c) begin
        rr_last <= RR_ST;
      end else if (hdr_gnt_c) begin
        rr_last <= RR_HDR;
      end
    end
  end

  // The tag travels with the read through its bus cycle, and it routes the sampled DQ to the issuing port.
  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      tag_q         <= TAG_NONE;
      disp_rvalid_q <= 1'b0;
      hdr_rvalid_q  <= 1'b0;
      disp_rdata_q  <= '0;
      hdr_rdata_q   <= '0;
    end else begin
      if (disp_gnt_c) begin
        tag_q <= TAG_DISP;
      end else if (hdr_gnt_c && !bus.hdr_we) begin
        tag_q <= TAG_HDR;
      end else begin
        tag_q <= TAG_NONE;
      end
      disp_rvalid_q <= (tag_q == TAG_DISP);
      hdr_rvalid_q  <= (tag_q == TAG_HDR);
      if (tag_q == TAG_DISP) begin
        disp_rdata_q <= io_SRAM_DQ;
      end
      if (tag_q == TAG_HDR) begin
        hdr_rdata_q <= io_SRAM_DQ;
      end
    end
  end

  assign bus.disp_gnt    = disp_gnt_c;
  assign bus.st_gnt      = st_gnt_c;
  assign bus.hdr_gnt     = hdr_gnt_c;
  assign bus.disp_rdata  = disp_rdata_q;
  assign bus.disp_rvalid = disp_rvalid_q;
  assign bus.hdr_rdata   = hdr_rdata_q;
  assign bus.hdr_rvalid  = hdr_rvalid_q;

  assign o_SRAM_ADDR = addr_q;
  assign o_SRAM_WE_N = we_n_q;
  assign o_SRAM_OE_N = oe_n_q;
  assign o_SRAM_CE_N = ce_n_q;
  assign o_SRAM_LB_N = 1'b0;
  assign o_SRAM_UB_N = 1'b0;
  assign io_SRAM_DQ  = dq_oe_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: covers reset, display reads, round-robin, read-after-write and reset mid-read.
// A small behavioural SRAM sits on the pins, and it is preloaded while reset is high.
module tb_sram_arbiter;
  localparam int AW = 20;
  localparam int DW = 16;

`ifdef SRAM_TURNAROUND_EN
  localparam int RR_NC  = 8;
  localparam int RR_REQ = 6;
  localparam logic [1:0] EXP_RR [0:7]  = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
  localparam logic       EXP_HRV [0:7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam logic [15:0] EXP_LAST_ST = 16'h2003;
`else
  localparam int RR_NC  = 6;
  localparam int RR_REQ = 4;
  localparam logic [1:0] EXP_RR [0:5]  = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00};
  localparam logic       EXP_HRV [0:5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [15:0] EXP_LAST_ST = 16'h2002;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_dq;
  logic          we_n, ce_n, oe_n, lb_n, ub_n;
  logic [DW-1:0] mem [0:63];

  int checks   = 0;
  int failures = 0;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .avm_clk     (clk),
    .avm_rst     (rst),
    .bus         (bus),
    .o_SRAM_ADDR (sram_addr),
    .io_SRAM_DQ  (sram_dq),
    .o_SRAM_WE_N (we_n),
    .o_SRAM_CE_N (ce_n),
    .o_SRAM_OE_N (oe_n),
    .o_SRAM_LB_N (lb_n),
    .o_SRAM_UB_N (ub_n)
  );

  assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[5:0]] : {DW{1'bz}};

  always @(posedge clk) begin
    if (rst) begin
      mem[6'h10] <= 16'hBEEF;
      mem[6'h30] <= 16'hA5A5;
      mem[6'h05] <= 16'h0000;
      mem[6'h20] <= 16'h0000;
    end else if (!ce_n && !we_n) begin
      mem[sram_addr[5:0]] <= sram_dq;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] gnts();
    return 32'({bus.disp_gnt, bus.st_gnt, bus.hdr_gnt});
  endfunction

  function automatic logic [31:0] strobes();
    return 32'({ce_n, oe_n, we_n});
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.disp_req  = 1'b1;
    bus.disp_addr = 20'h00010;
    bus.st_req    = 1'b1;
    bus.st_addr   = 20'h00005;
    bus.st_wdata  = 16'h1234;
    bus.hdr_req   = 1'b1;
    bus.hdr_we    = 1'b0;
    bus.hdr_addr  = 20'h00005;
    bus.hdr_wdata = 16'h0000;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_gnt", gnts(), 32'(3'b000));
      check("rst_strobe", strobes(), 32'(3'b111));
    end
    check("rst_addr", 32'(sram_addr), 32'h0);
    check("rst_rvalid", 32'({bus.disp_rvalid, bus.hdr_rvalid}), 32'h0);
    check("rst_disp_rdata", 32'(bus.disp_rdata), 32'h0);
    check("rst_hdr_rdata", 32'(bus.hdr_rdata), 32'h0);
    check("byte_en", 32'({lb_n, ub_n}), 32'h0);

    // Display reads while st and hdr both wait
    next_cyc(); rst = 1'b0;
    @(negedge clk);
    check("r0_gnt", gnts(), 32'(3'b100));
    next_cyc();
    @(negedge clk);
    check("r1_gnt", gnts(), 32'(3'b100));
    check("r1_strobe", strobes(), 32'(3'b001));
    check("r1_addr", 32'(sram_addr), 32'h10);
    next_cyc();
    @(negedge clk);
    check("r2_gnt", gnts(), 32'(3'b100));
    check("r2_disp_rvalid", 32'(bus.disp_rvalid), 32'h1);
    check("r2_disp_rdata", 32'(bus.disp_rdata), 32'hBEEF);
    next_cyc(); bus.disp_req = 1'b0;
    @(negedge clk);
    check("r3_gnt_st_first", gnts(), 32'(3'b010));
    check("r3_disp_rvalid", 32'(bus.disp_rvalid), 32'h1);
    check("r3_strobe", strobes(), 32'(3'b001));
    next_cyc(); bus.st_req = 1'b0;
    @(negedge clk);
    check("r4_strobe_wr", strobes(), 32'(3'b010));
    check("r4_addr", 32'(sram_addr), 32'h5);
    check("r4_dq", 32'(sram_dq), 32'h1234);
    check("r4_disp_rvalid", 32'(bus.disp_rvalid), 32'h1);
`ifdef SRAM_TURNAROUND_EN
    check("raw_bubble_gnt", gnts(), 32'(3'b000));
    next_cyc();
    @(negedge clk);
    check("raw_bubble_bus", strobes(), 32'(3'b111));
    check("raw_gnt", gnts(), 32'(3'b001));
`else
    check("raw_gnt", gnts(), 32'(3'b001));
`endif
    next_cyc(); bus.hdr_req = 1'b0;
    @(negedge clk);
    check("raw_rd_strobe", strobes(), 32'(3'b001));
    check("raw_rd_addr", 32'(sram_addr), 32'h5);
    check("raw_rvalid_early", 32'({bus.disp_rvalid, bus.hdr_rvalid}), 32'h0);
    next_cyc();
    @(negedge clk);
    check("raw_hdr_rvalid", 32'(bus.hdr_rvalid), 32'h1);
    check("raw_hdr_rdata", 32'(bus.hdr_rdata), 32'h1234);
    check("raw_idle", strobes(), 32'(3'b111));
    next_cyc();

    // Round-robin between st writes and hdr reads
    bus.st_addr  = 20'h00020;
    bus.hdr_addr = 20'h00030;
    bus.hdr_we   = 1'b0;
    for (int c = 0; c < RR_NC; c++) begin
      bus.st_req   = (c < RR_REQ);
      bus.hdr_req  = (c < RR_REQ);
      bus.st_wdata = 16'h2000 + 16'(c);
      @(negedge clk);
      check("rr_gnt", 32'({bus.st_gnt, bus.hdr_gnt}), 32'(EXP_RR[c]));
      check("rr_disp_gnt", 32'(bus.disp_gnt), 32'h0);
      check("rr_hdr_rvalid", 32'(bus.hdr_rvalid), 32'(EXP_HRV[c]));
      next_cyc();
    end
    check("rr_hdr_rdata", 32'(bus.hdr_rdata), 32'hA5A5);
    check("rr_st_mem", 32'(mem[6'h20]), 32'(EXP_LAST_ST));

    // Reset one cycle after an hdr read grant
    bus.hdr_req  = 1'b1;
    bus.hdr_addr = 20'h00010;
    @(negedge clk);
    check("mid_gnt", gnts(), 32'(3'b001));
    next_cyc(); bus.hdr_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("mid_bus_read", strobes(), 32'(3'b001));
    next_cyc(); rst = 1'b0;
    @(negedge clk);
    check("mid_rvalid_a", 32'(bus.hdr_rvalid), 32'h0);
    check("mid_idle_a", strobes(), 32'(3'b111));
    check("mid_rdata_cleared", 32'(bus.hdr_rdata), 32'h0);
    next_cyc();
    @(negedge clk);
    check("mid_rvalid_b", 32'(bus.hdr_rvalid), 32'h0);
    check("mid_idle_b", strobes(), 32'(3'b111));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
